// File: rtl/wb_frame_pkg.sv
// wb_frame_pkg: shared FSM state type and Wishbone constants for the frame reader
package wb_frame_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RETRY, WAIT} state_t;
  localparam int WB_DW = 32;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;
endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone classic bundle (clk, rst, cyc, stb, we, adr, sel, dat_ms, dat_sm, ack, err, rty) with master/slave modports
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic                           cyc;
  logic                           stb;
  logic                           we;
  logic [31:0]                    adr;
  logic [3:0]                     sel;
  logic [wb_frame_pkg::WB_DW-1:0] dat_ms;
  logic [wb_frame_pkg::WB_DW-1:0] dat_sm;
  logic                           ack;
  logic                           err;
  logic                           rty;
  modport master (input clk, rst, dat_sm, ack, err, rty, output cyc, stb, we, adr, sel, dat_ms);
  modport slave (input clk, rst, cyc, stb, we, adr, sel, dat_ms, output dat_sm, ack, err, rty);
endinterface

// File: rtl/wb_sync_fifo.sv
// wb_sync_fifo: first-word-fall-through sync FIFO; in clk, rst, push, din, pop; out dout (0 when empty), empty, full, count
module wb_sync_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          wr, rd;
  always_comb begin
    empty = count == '0;
    full  = count == (AW+1)'(DEPTH);
    wr    = push && !full;
    rd    = pop && !empty;
    dout  = empty ? '0 : mem[rptr];
  end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wr ? wptr + 1'b1 : wptr;
      rptr  <= rd ? rptr + 1'b1 : rptr;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/wb_frame_reader.sv
// wb_frame_reader: Wishbone master streaming NWORDS words from base_adr into a FIFO; ports wb_m, start, base_adr, busy, done, error, pix_data/valid/ready
module wb_frame_reader
  import wb_frame_pkg::*;
#(
  parameter int NWORDS  = 1024,
  parameter int FIFO_AW = 4,
  parameter int MAX_RTY = 7
) (
  wshb_if.master           wb_m,
  input  logic             start,
  input  logic [31:0]      base_adr,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WB_DW-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(NWORDS + 1);
  localparam int RW    = $clog2(MAX_RTY + 2);
  logic             clk, rst;
  state_t           state, state_n;
  logic [31:0]      adr;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    rtry;
  logic             cyc, stb, ack_ok, rty_ok, abort, last, fills, pop, empty, full;
  logic [FIFO_AW:0] fcount;
  assign clk = wb_m.clk;
  assign rst = wb_m.rst;
  assign wb_m.cyc    = cyc;
  assign wb_m.stb    = stb;
  assign wb_m.we     = 1'b0;
  assign wb_m.adr    = adr;
  assign wb_m.sel    = WB_SEL_ALL;
  assign wb_m.dat_ms = '0;
  assign pix_valid   = !empty;
  assign pop         = pix_valid && pix_ready;
  always_comb begin
    abort  = stb && (wb_m.err || (wb_m.rty && rtry == RW'(MAX_RTY)));
    rty_ok = stb && wb_m.rty && !abort;
    ack_ok = stb && wb_m.ack && !wb_m.err && !wb_m.rty;
    last   = cnt == CW'(NWORDS - 1);
    fills  = fcount == (FIFO_AW+1)'(DEPTH - 1) && !pop;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (full ? WAIT : REQ) : IDLE;
      WAIT:    state_n = full ? WAIT : REQ;
      REQ:     state_n = abort ? IDLE : rty_ok ? RETRY : ack_ok ? (last ? IDLE : fills ? WAIT : REQ) : REQ;
      RETRY:   state_n = REQ;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    cyc  = state == REQ || state == RETRY;
    stb  = state == REQ;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      adr   <= '0;
      cnt   <= '0;
      rtry  <= '0;
      error <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= ack_ok && last;
      if (state == IDLE && start) begin
        adr   <= base_adr & ~32'h3;
        cnt   <= '0;
        rtry  <= '0;
        error <= 1'b0;
      end
      if (abort) error <= 1'b1;
      if (rty_ok) rtry <= rtry + 1'b1;
      if (ack_ok) begin
        adr  <= adr + 32'd4;
        cnt  <= cnt + 1'b1;
        rtry <= '0;
      end
    end
  end
  wb_sync_fifo #(.DW(WB_DW), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ack_ok),
    .din   (wb_m.dat_sm),
    .pop   (pop),
    .dout  (pix_data),
    .empty (empty),
    .full  (full),
    .count (fcount)
  );
endmodule

// File: tb/tb_wb_frame_reader.sv
// tb_wb_frame_reader: randomized bench with a queue-based frame model and a Wishbone slave model
module tb_wb_frame_reader;
  localparam int NW = 24, DEPTH = 16, MAXR = 7;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  wshb_if wb (.clk(clk), .rst(rst));
  logic start = 0, pix_ready = 0;
  logic [31:0] base_adr = 0;
  logic busy, done, error, pix_valid;
  logic [31:0] pix_data;
  wb_frame_reader #(.NWORDS(NW), .FIFO_AW(4), .MAX_RTY(MAXR)) dut (
    .wb_m(wb), .start(start), .base_adr(base_adr), .busy(busy), .done(done), .error(error),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready)
  );
  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction
  logic [31:0] err_at = '1, rty_at = '1;
  int rty_n = 0, rty_seen = 0, pr_mode = 0;
  always @(posedge clk) begin
    wb.ack <= 0;
    wb.err <= 0;
    wb.rty <= 0;
    wb.dat_sm <= $urandom;
    if (rst) rty_seen <= 0;
    else if (wb.cyc === 1'b1 && wb.stb === 1'b1 && !(wb.ack || wb.err || wb.rty) && $urandom_range(0, 3) != 0) begin
      if (wb.adr == err_at) wb.err <= 1;
      else if (wb.adr == rty_at && rty_seen < rty_n) begin
        wb.rty <= 1;
        rty_seen <= rty_seen + 1;
      end else begin
        wb.ack <= 1;
        wb.dat_sm <= mem_word(wb.adr);
      end
    end
  end
  always @(posedge clk) begin
    #1;
    pix_ready = pr_mode == 2 ? 1'($urandom_range(0, 1)) : pr_mode == 1;
  end
  logic [31:0] mq[$], pops[$], m_adr;
  bit m_busy, m_done, m_err, armed, gap;
  int m_n, m_rty, prev_cnt, ack_cnt, done_cnt, t8;
  always @(negedge clk) begin
    if (armed) begin
      chk("we", wb.we, 0);
      chk("sel", wb.sel, 4'hF);
      chk("adr_align", wb.adr[1:0], 0);
      chk("dat_ms", wb.dat_ms, 0);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("pix_valid", pix_valid, mq.size() != 0);
      if (mq.size() != 0) chk("pix_data", pix_data, mq[0]);
      if (wb.stb) begin
        chk("stb_cyc", wb.cyc, 1);
        chk("stb_room", mq.size() < DEPTH, 1);
        chk("stb_adr", wb.adr, m_adr);
      end
      if (!m_busy) chk("idle_cyc", wb.cyc, 0);
      if (gap) begin
        chk("rty_gap_stb", wb.stb, 0);
        chk("rty_gap_cyc", wb.cyc, 1);
      end else if (m_busy && prev_cnt < DEPTH && mq.size() < DEPTH) chk("stb_live", wb.stb, 1);
      if (done) done_cnt++;
    end
    prev_cnt = mq.size();
    gap = 0;
    m_done = 0;
    if (rst) begin
      mq.delete();
      m_busy = 0;
      m_err = 0;
      m_n = 0;
      m_rty = 0;
      armed = 1;
    end else if (armed) begin
      if (pix_ready && mq.size() != 0) pops.push_back(mq.pop_front());
      if (!m_busy && start) begin
        m_busy = 1;
        m_adr = base_adr & ~32'h3;
        m_n = 0;
        m_err = 0;
        m_rty = 0;
      end else if (m_busy && wb.stb && (wb.err || wb.rty || wb.ack)) begin
        if (wb.adr == 32'h8) t8++;
        if (wb.err || (wb.rty && m_rty == MAXR)) begin
          m_err = 1;
          m_busy = 0;
        end else if (wb.rty) begin
          m_rty++;
          gap = 1;
        end else begin
          mq.push_back(mem_word(m_adr));
          m_adr += 4;
          m_n++;
          m_rty = 0;
          ack_cnt++;
          if (m_n == NW) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic do_start(input logic [31:0] b);
    @(posedge clk);
    #1 start = 1;
    base_adr = b;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (m_busy && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #2 chk("frame_timeout", m_busy, 0);
  endtask
  task automatic drain();
    int k = 0;
    pr_mode = 1;
    while (mq.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #2 chk("drain_timeout", mq.size(), 0);
  endtask
  initial begin
    int a0, d0, p0, t0, k;
    logic [31:0] b;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    tick(10);
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_stb", wb.stb, 0);
    chk("rst_adr", wb.adr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_error", error, 0);
    chk("rst_pix_data", pix_data, 0);
    pr_mode = 1;
    do_start(32'h0);
    wait_idle();
    drain();
    chk("s2_first", pops[0], 32'hA000_0000);
    chk("s2_last", pops[NW-1], 32'hA000_0017);
    chk("s2_done", done_cnt, 1);
    pr_mode = 0;
    a0 = ack_cnt;
    p0 = pops.size();
    tick(1);
    do_start(32'h0);
    tick(100);
    chk("s3_acks", ack_cnt - a0, 16);
    chk("s3_stb", wb.stb, 0);
    chk("s3_adr", wb.adr, 32'h40);
    chk("s3_busy", busy, 1);
    pr_mode = 1;
    wait_idle();
    drain();
    chk("s3_pops", pops.size() - p0, NW);
    chk("s3_last", pops[$], 32'hA000_0017);
    do_reset();
    rty_at = 32'h8;
    rty_n = 2;
    t0 = t8;
    d0 = done_cnt;
    do_start(32'h0);
    wait_idle();
    drain();
    chk("s4_issues_08", t8 - t0, 3);
    chk("s4_done", done_cnt - d0, 1);
    chk("s4_error", error, 0);
    rty_at = '1;
    pr_mode = 0;
    err_at = 32'hC;
    a0 = ack_cnt;
    d0 = done_cnt;
    do_start(32'h0);
    wait_idle();
    tick(3);
    chk("s5_acks", ack_cnt - a0, 3);
    chk("s5_error", error, 1);
    chk("s5_busy", busy, 0);
    chk("s5_done", done_cnt - d0, 0);
    chk("s5_head", pix_data, 32'hA000_0000);
    err_at = '1;
    do_start(32'h1000);
    chk("s5_clear", error, 0);
    pr_mode = 1;
    wait_idle();
    drain();
    chk("s5_last", pops[$], 32'hA000_0417);
    rty_at = 32'h2008;
    rty_n = 8;
    do_reset();
    a0 = ack_cnt;
    d0 = done_cnt;
    do_start(32'h2000);
    wait_idle();
    drain();
    chk("s6_acks", ack_cnt - a0, 2);
    chk("s6_error", error, 1);
    chk("s6_done", done_cnt - d0, 0);
    for (int i = 0; i < 6; i++) begin
      b = i == 0 ? 32'hFFFF_FFE3 : $urandom;
      rty_at = (b & ~32'h3) + 32'(4 * $urandom_range(0, NW - 1));
      rty_n = $urandom_range(0, 3);
      do_reset();
      pr_mode = 2;
      do_start(b);
      tick(5);
      do_start(b ^ 32'h0F00_0000);
      wait_idle();
      drain();
    end
    chk("s7_wrap_word", pops[pops.size() - 6*NW + 8], 32'hA000_0000);
    rty_at = '1;
    pr_mode = 0;
    a0 = ack_cnt;
    d0 = done_cnt;
    do_start(32'h100);
    k = 0;
    while (ack_cnt - a0 < 5 && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("s8_acks_timeout", ack_cnt - a0 >= 5, 1);
    do_reset();
    chk("s8_cyc", wb.cyc, 0);
    chk("s8_stb", wb.stb, 0);
    chk("s8_valid", pix_valid, 0);
    chk("s8_busy", busy, 0);
    tick(5);
    chk("s8_done", done_cnt - d0, 0);
    pr_mode = 1;
    do_start(32'h300);
    wait_idle();
    drain();
    chk("s8_last", pops[$], 32'hA000_00D7);
    chk("s8_done_after", done_cnt - d0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_frame_reader.md
Name: wb_frame_reader

Overview:
- Wishbone classic master that streams a contiguous region of word-addressed memory (e.g. a wb_bram frame buffer) to a pixel consumer.
- On a start pulse it issues single-word read cycles over a wshb_if master modport and pushes returned words into an internal FIFO.
- The FIFO drains through a valid/ready stream.
- Sits between the memory controller's Wishbone slaves and the video output pipeline.

Parameters:
- NWORDS, 1024, number of 32-bit words read per start pulse (≥1).
- FIFO_AW, 4, log2 of internal FIFO depth (depth 16).
- MAX_RTY, 7, retries of one address before abort.

Ports:
- wb_m.clk  input  1  single clock, carried in wshb_if.
- wb_m.rst  input  1  synchronous, active-high reset, carried in wshb_if.
- wb_m.cyc/stb/we  output  1 each  Wishbone master controls.
- wb_m.adr  output  32  byte address.
- wb_m.sel  output  4  byte enables.
- wb_m.dat_ms  output  32  write data, tied 0.
- wb_m.dat_sm  input  32  read data.
- wb_m.ack/err/rty  input  1 each  slave terminations.
- start  input  1  one-cycle pulse, begin frame read.
- base_adr  input  32  byte start address, sampled on start; bits [1:0] ignored (forced 0).
- busy  output  1  frame read in progress.
- done  output  1  one-cycle pulse after the last word is accepted into the FIFO.
- error  output  1  sticky abort flag, cleared by next accepted start.
- pix_data  output  32  FIFO head word.
- pix_valid  output  1  FIFO not empty.
- pix_ready  input  1  consumer accepts pix_data when pix_valid && pix_ready.

Behaviour:
- Reset (wb_m.rst=1 at posedge): all of the following cleared.
  - cyc=stb=we=0, adr=0, sel=4'hF, dat_ms=0.
  - busy=done=error=0, pix_valid=0, pix_data=0.
  - FIFO emptied, word counter=0, retry counter=0, state IDLE.
  - Reset mid-frame aborts at once: no done pulse, FIFO contents discarded.
- we is always 0; sel is always 4'hF; adr is always word aligned.
- State IDLE:
  - start=1 → latch adr={base_adr[31:2],2'b00}, count=0, clear error, busy=1.
  - Then go to REQ if FIFO not full, else WAIT.
  - start while busy is ignored.
- State WAIT: cyc=stb=0. Go to REQ on the first cycle FIFO count < depth.
- State REQ: cyc=stb=1, holding adr stable until a termination is seen.
  - ack: push dat_sm into FIFO the same edge, count++, adr+=4, retry=0.
    - If count reaches NWORDS: go to IDLE, busy=0, done=1 for one cycle; cyc/stb low next cycle.
    - Else if FIFO becomes full (after push, considering a same-cycle pop): go to WAIT.
    - Else stay in REQ with the next address; back-to-back reads, one word per ack.
  - rty: no push. retry++, drop stb for one cycle (RETRY state, cyc kept 1), then re-issue the same adr.
    - retry reaching MAX_RTY+1 behaves as err.
  - err: no push. error=1, busy=0, go to IDLE, cyc/stb drop next cycle, no done pulse.
  - Termination priority when several are asserted: err > rty > ack.
- stb is asserted only when a FIFO slot is free. An ack therefore never overflows: at most one request is outstanding.
- FIFO: synchronous, first-word-fall-through.
  - pix_data is valid in the same cycle pix_valid=1.
  - Push and pop in the same cycle on a full FIFO is legal only for pop; push is prevented by the rule above.
  - Push and pop on a non-full FIFO leave count unchanged.
- Address wraps modulo 2^32 without error.
- FIFO keeps draining after done; a new start is allowed while the FIFO is non-empty.

Decomposition:
- Package wb_frame_pkg:
  - state enum {IDLE, REQ, RETRY, WAIT}.
  - constants WB_DW=32, WB_SEL_ALL=4'hF.
- Sub-module wb_sync_fifo (params DW, AW), with ports clk, rst, push, din, pop, dout, empty, full, count.
  - Instantiated once for the FIFO; the top holds the FSM and counters.

Test Plan:
- Reset, then idle 10 cycles → cyc=stb=0, busy=0, pix_valid=0, error=0.
- Preload wb_bram word i = 32'hA000_0000+i; start with base_adr=0, NWORDS=8, pix_ready=1.
  - → adr sequence 0x00,0x04..0x1C.
  - → pix_data A0000000..A0000007 in order.
  - → one done pulse, busy low after last ack.
- Same preload, NWORDS=40, pix_ready=0 until cycle 100.
  - → exactly 16 acks, then stb low with adr=0x40 pending.
  - → after pix_ready=1, all 40 words arrive in order, none lost or duplicated.
- Slave model asserts rty twice at adr 0x08, then ack.
  - → 0x08 is issued 3 times, word pushed once, done pulses, error=0.
- Slave asserts err at adr 0x0C.
  - → 3 words in FIFO, error=1, busy=0, no done.
  - → next start clears error.
- Reset asserted mid-frame (after 5 acks) → next cycle cyc=stb=0, FIFO empty, no done; a subsequent start reads from base_adr correctly.
